// File: rtl/sram_oq_writer_if.sv
// sram_oq_writer_if: arbiter input, free, SRAM write and commit signals of sram_oq_writer.
// drop_count exists only when SRAM_OQ_DROP_CNT_EN is defined.
interface sram_oq_writer_if #(
    parameter int NUM_QUEUES  = 5,
    parameter int QADDR_WIDTH = 10,
    parameter int DATA_WIDTH  = 202
);
    logic [DATA_WIDTH-1:0]    din;
    logic                     din_valid;
    logic [2:0]               queue_id;
    logic                     free_valid;
    logic [2:0]               free_queue_id;
    logic [QADDR_WIDTH+2:0]   sram_addr;
    logic [DATA_WIDTH-1:0]    sram_wdata;
    logic                     sram_we;
    logic [NUM_QUEUES-1:0]    queue_nonempty;
    logic                     commit_valid;
    logic [2:0]               commit_queue;
    logic [QADDR_WIDTH:0]     commit_words;
`ifdef SRAM_OQ_DROP_CNT_EN
    logic [NUM_QUEUES*16-1:0] drop_count;

    modport master (
        output din, din_valid, queue_id, free_valid, free_queue_id,
        input  sram_addr, sram_wdata, sram_we, queue_nonempty, commit_valid, commit_queue, commit_words, drop_count
    );
    modport slave (
        input  din, din_valid, queue_id, free_valid, free_queue_id,
        output sram_addr, sram_wdata, sram_we, queue_nonempty, commit_valid, commit_queue, commit_words, drop_count
    );
`else
    modport master (
        output din, din_valid, queue_id, free_valid, free_queue_id,
        input  sram_addr, sram_wdata, sram_we, queue_nonempty, commit_valid, commit_queue, commit_words
    );
    modport slave (
        input  din, din_valid, queue_id, free_valid, free_queue_id,
        output sram_addr, sram_wdata, sram_we, queue_nonempty, commit_valid, commit_queue, commit_words
    );
`endif
endinterface

// File: rtl/sram_oq_writer.sv
// sram_oq_writer: writes arbiter packets into per-queue SRAM rings, commits whole packets, rolls back dropped ones.
// Defining SRAM_OQ_DROP_CNT_EN adds saturating per-queue drop counters on drop_count.
module sram_oq_writer #(
    parameter int NUM_QUEUES  = 5,
    parameter int QADDR_WIDTH = 10,
    parameter int DATA_WIDTH  = 202
) (
    input logic             memclk,
    input logic             memreset,
    sram_oq_writer_if.slave bus
);
    localparam int QW = QADDR_WIDTH;
    localparam logic [QW:0] CAP = {1'b1, {QW{1'b0}}};

    typedef enum logic [1:0] {IDLE, WRITE, DROP} state_t;

    state_t                state, state_nx;
    logic [QW-1:0]         wr_ptr    [NUM_QUEUES];
    logic [QW-1:0]         ptr_base  [NUM_QUEUES];
    logic [QW-1:0]         ptr_nx    [NUM_QUEUES];
    logic [QW:0]           fill      [NUM_QUEUES];
    logic [QW:0]           fill_base [NUM_QUEUES];
    logic [QW:0]           fill_nx   [NUM_QUEUES];
    logic [QW:0]           committed [NUM_QUEUES];
    logic [QW:0]           com_nx    [NUM_QUEUES];
    logic [QW-1:0]         pkt_start;
    logic [QW:0]           pkt_len, len_nx;
    logic [2:0]            pkt_q, wr_q, qsel, fsel;
    logic                  hdr, last, qid_ok, fid_ok, rb, wr, start, commit, fr;
    logic [NUM_QUEUES-1:0] nonempty;

    assign hdr    = bus.din[4:2] == 3'd0;
    assign last   = bus.din[1];
    assign qid_ok = int'(bus.queue_id) < NUM_QUEUES;
    assign fid_ok = int'(bus.free_queue_id) < NUM_QUEUES;
    assign qsel   = qid_ok ? bus.queue_id : 3'd0;
    assign fsel   = fid_ok ? bus.free_queue_id : 3'd0;
    assign fr     = bus.free_valid && fid_ok && committed[fsel] != '0;
    // The open packet is abandoned on overflow or when a new header truncates it
    assign rb     = bus.din_valid && state == WRITE && (hdr || fill[pkt_q] == CAP);
    assign len_nx = start ? (QW+1)'(1) : pkt_len + (QW+1)'(1);
    assign bus.queue_nonempty = nonempty;

    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            ptr_base[i]  = (rb && int'(pkt_q) == i) ? pkt_start : wr_ptr[i];
            fill_base[i] = (rb && int'(pkt_q) == i) ? fill[i] - pkt_len : fill[i];
        end
    end

    always_comb begin
        state_nx = state;
        wr       = 1'b0;
        start    = 1'b0;
        commit   = 1'b0;
        wr_q     = pkt_q;
        if (bus.din_valid) begin
            if (state == DROP) begin
                state_nx = last ? IDLE : DROP;
            end else if (state == WRITE && !hdr) begin
                wr       = !rb;
                commit   = !rb && last;
                state_nx = last ? IDLE : (rb ? DROP : WRITE);
            end else if (hdr) begin
                if (!qid_ok || fill_base[qsel] == CAP) begin
                    state_nx = last ? IDLE : DROP;
                end else begin
                    wr       = 1'b1;
                    start    = 1'b1;
                    wr_q     = qsel;
                    commit   = last;
                    state_nx = last ? IDLE : WRITE;
                end
            end
        end
    end

    // Rollback, write and free all fold into one update per queue
    always_comb begin
        for (int i = 0; i < NUM_QUEUES; i++) begin
            ptr_nx[i]   = ptr_base[i] + QW'(wr && int'(wr_q) == i);
            fill_nx[i]  = fill_base[i] + (QW+1)'(wr && int'(wr_q) == i) - (QW+1)'(fr && int'(fsel) == i);
            com_nx[i]   = committed[i] + ((commit && int'(wr_q) == i) ? len_nx : '0) - (QW+1)'(fr && int'(fsel) == i);
            nonempty[i] = committed[i] != '0;
        end
    end

    always_ff @(posedge memclk or negedge memreset) begin
        if (!memreset) begin
            state            <= IDLE;
            wr_ptr           <= '{default: '0};
            fill             <= '{default: '0};
            committed        <= '{default: '0};
            pkt_start        <= '0;
            pkt_len          <= '0;
            pkt_q            <= '0;
            bus.sram_we      <= 1'b0;
            bus.sram_addr    <= '0;
            bus.sram_wdata   <= '0;
            bus.commit_valid <= 1'b0;
            bus.commit_queue <= '0;
            bus.commit_words <= '0;
        end else begin
            state            <= state_nx;
            wr_ptr           <= ptr_nx;
            fill             <= fill_nx;
            committed        <= com_nx;
            pkt_len          <= wr ? len_nx : pkt_len;
            bus.sram_we      <= wr;
            bus.commit_valid <= commit;
            if (start) begin
                pkt_start <= ptr_base[wr_q];
                pkt_q     <= wr_q;
            end
            if (wr) begin
                bus.sram_addr  <= {wr_q, ptr_base[wr_q]};
                bus.sram_wdata <= bus.din;
            end
            if (commit) begin
                bus.commit_queue <= wr_q;
                bus.commit_words <= len_nx;
            end
        end
    end

`ifdef SRAM_OQ_DROP_CNT_EN
    logic [15:0] drop_cnt [NUM_QUEUES];
    logic        hdr_full;

    assign hdr_full = bus.din_valid && hdr && state != DROP && qid_ok && fill_base[qsel] == CAP;

    always_ff @(posedge memclk or negedge memreset) begin
        if (!memreset) begin
            drop_cnt <= '{default: '0};
        end else begin
            for (int i = 0; i < NUM_QUEUES; i++)
                if (((rb && int'(pkt_q) == i) || (hdr_full && int'(qsel) == i)) && drop_cnt[i] != 16'hFFFF)
                    drop_cnt[i] <= drop_cnt[i] + 16'd1;
        end
    end

    always_comb begin
        bus.drop_count = '0;
        for (int i = 0; i < NUM_QUEUES; i++)
            bus.drop_count[i*16 +: 16] = drop_cnt[i];
    end
`endif
endmodule

// File: tb/tb_sram_oq_writer.sv
// tb_sram_oq_writer: directed vector table, reset corner cases and a randomized run against a queue-level model.
module tb_sram_oq_writer;
    localparam int NQ  = 5;
    localparam int QW  = 3;
    localparam int DW  = 202;
    localparam int CAP = 8;

    typedef struct {
        bit       v;
        bit [2:0] typ;
        bit       last;
        bit [2:0] q;
        bit       fv;
        bit [2:0] fq;
        bit       we;
        bit [5:0] addr;
        bit       cv;
        bit [2:0] cq;
        bit [3:0] cw;
        bit [4:0] ne;
    } vec_t;

    logic memclk = 1'b0;
    logic memreset = 1'b0;
    int   n_vec = 0;
    int   n_bad = 0;

    sram_oq_writer_if #(.NUM_QUEUES(NQ), .QADDR_WIDTH(QW), .DATA_WIDTH(DW)) bus();
    sram_oq_writer #(.NUM_QUEUES(NQ), .QADDR_WIDTH(QW), .DATA_WIDTH(DW)) dut (
        .memclk  (memclk),
        .memreset(memreset),
        .bus     (bus)
    );

    always #5 memclk = ~memclk;

    // Reference model: per-queue ring pointers, occupancy and committed counts
    int m_wp[NQ], m_fill[NQ], m_com[NQ], m_drop[NQ];
    int m_mode, m_q, m_len;
    bit e_we, e_cv;
    logic [5:0] e_addr;
    logic [DW-1:0] e_data;
    int e_cq, e_cw;

    task automatic m_reset();
        for (int i = 0; i < NQ; i++) begin
            m_wp[i] = 0; m_fill[i] = 0; m_com[i] = 0; m_drop[i] = 0;
        end
        m_mode = 0; m_q = 0; m_len = 0;
    endtask

    task automatic m_rollback();
        m_wp[m_q] = (m_wp[m_q] - m_len + CAP) % CAP;
        m_fill[m_q] -= m_len;
        m_drop[m_q]++;
    endtask

    task automatic m_write(int q, logic [DW-1:0] d, bit last);
        e_we = 1; e_addr = 6'(q * CAP + m_wp[q]); e_data = d;
        m_wp[q] = (m_wp[q] + 1) % CAP;
        m_fill[q]++;
        m_len++;
        if (last) begin
            m_com[q] += m_len; e_cv = 1; e_cq = q; e_cw = m_len; m_mode = 0;
        end else m_mode = 1;
    endtask

    task automatic m_cycle(bit v, logic [DW-1:0] d, int q, bit fv, int fq);
        bit hdr, last, fr;
        hdr = d[4:2] == 3'd0;
        last = d[1];
        fr = fv && fq < NQ && m_com[fq] > 0;
        e_we = 0; e_cv = 0;
        if (v) begin
            if (m_mode == 1 && hdr) begin m_rollback(); m_mode = 0; end
            if (m_mode == 2) m_mode = last ? 0 : 2;
            else if (m_mode == 1) begin
                if (m_fill[m_q] == CAP) begin m_rollback(); m_mode = last ? 0 : 2; end
                else m_write(m_q, d, last);
            end else if (hdr) begin
                if (q >= NQ) m_mode = last ? 0 : 2;
                else if (m_fill[q] == CAP) begin m_drop[q]++; m_mode = last ? 0 : 2; end
                else begin m_q = q; m_len = 0; m_write(q, d, last); end
            end
        end
        if (fr) begin m_fill[fq]--; m_com[fq]--; end
    endtask

    function automatic logic [4:0] m_ne();
        logic [4:0] r;
        for (int i = 0; i < NQ; i++) r[i] = m_com[i] != 0;
        return r;
    endfunction

    function automatic vec_t mk(int v, int typ, int last, int q, int fv, int fq,
                                int we, int addr, int cv, int cq, int cw, int ne);
        vec_t r;
        r.v = v[0]; r.typ = typ[2:0]; r.last = last[0]; r.q = q[2:0]; r.fv = fv[0]; r.fq = fq[2:0];
        r.we = we[0]; r.addr = addr[5:0]; r.cv = cv[0]; r.cq = cq[2:0]; r.cw = cw[3:0]; r.ne = ne[4:0];
        return r;
    endfunction

    function automatic logic [DW-1:0] mkd(int typ, int last);
        logic [DW-1:0] d = '0;
        for (int k = 0; k < 7; k++) d = (d << 32) | DW'($urandom);
        d[4:2] = typ[2:0];
        d[1] = last[0];
        return d;
    endfunction

    task automatic drive(bit v, logic [DW-1:0] d, int q, bit fv, int fq);
        bus.din_valid = v; bus.din = d; bus.queue_id = 3'(q);
        bus.free_valid = fv; bus.free_queue_id = 3'(fq);
    endtask

    task automatic chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    task automatic cmp_out(bit we, logic [5:0] addr, logic [DW-1:0] data, bit cv, int cq, int cw, logic [4:0] ne);
        chk("sram_we", bus.sram_we, we);
        if (we) begin
            chk("sram_addr", bus.sram_addr, addr);
            chk("sram_wdata", bus.sram_wdata, data);
        end
        chk("commit_valid", bus.commit_valid, cv);
        if (cv) begin
            chk("commit_queue", bus.commit_queue, cq);
            chk("commit_words", bus.commit_words, cw);
        end
        chk("queue_nonempty", bus.queue_nonempty, ne);
    endtask

    task automatic chk_zero(string tag);
        chk({tag, "_we"}, bus.sram_we, 0);
        chk({tag, "_addr"}, bus.sram_addr, 0);
        chk({tag, "_wdata"}, bus.sram_wdata, 0);
        chk({tag, "_cv"}, bus.commit_valid, 0);
        chk({tag, "_cq"}, bus.commit_queue, 0);
        chk({tag, "_cw"}, bus.commit_words, 0);
        chk({tag, "_ne"}, bus.queue_nonempty, 0);
    endtask

    initial begin
        vec_t tv[$];
        logic [DW-1:0] d;
        int rq, rtyp, rlast;
        bit rv, rfv;
        int rfq;

        tv.push_back(mk(1,0,0,2, 0,0, 1,16, 0,0,0, 'b00000));
        tv.push_back(mk(1,1,0,2, 0,0, 1,17, 0,0,0, 'b00000));
        tv.push_back(mk(1,2,0,2, 0,0, 1,18, 0,0,0, 'b00000));
        tv.push_back(mk(1,1,1,2, 0,0, 1,19, 1,2,4, 'b00100));
        tv.push_back(mk(1,1,0,0, 0,0, 0,0,  0,0,0, 'b00100));
        tv.push_back(mk(1,0,0,3, 0,0, 1,24, 0,0,0, 'b00100));
        tv.push_back(mk(1,1,0,3, 0,0, 1,25, 0,0,0, 'b00100));
        tv.push_back(mk(1,0,0,3, 0,0, 1,24, 0,0,0, 'b00100));
        tv.push_back(mk(1,1,1,3, 0,0, 1,25, 1,3,2, 'b01100));
        tv.push_back(mk(1,0,1,4, 0,0, 1,32, 1,4,1, 'b11100));
        tv.push_back(mk(1,0,0,4, 1,4, 1,33, 0,0,0, 'b01100));
        tv.push_back(mk(1,1,1,4, 0,0, 1,34, 1,4,2, 'b11100));
        tv.push_back(mk(0,0,0,0, 1,0, 0,0,  0,0,0, 'b11100));
        tv.push_back(mk(0,0,0,0, 1,6, 0,0,  0,0,0, 'b11100));
        tv.push_back(mk(1,0,0,5, 0,0, 0,0,  0,0,0, 'b11100));
        tv.push_back(mk(1,1,1,5, 0,0, 0,0,  0,0,0, 'b11100));
        tv.push_back(mk(1,1,1,0, 0,0, 0,0,  0,0,0, 'b11100));
        tv.push_back(mk(1,0,0,0, 0,0, 1,0,  0,0,0, 'b11100));
        for (int k = 1; k <= 4; k++) tv.push_back(mk(1,1,0,0, 0,0, 1,k, 0,0,0, 'b11100));
        tv.push_back(mk(1,1,1,0, 0,0, 1,5,  1,0,6, 'b11101));
        tv.push_back(mk(1,0,0,0, 0,0, 1,6,  0,0,0, 'b11101));
        tv.push_back(mk(1,1,0,0, 0,0, 1,7,  0,0,0, 'b11101));
        tv.push_back(mk(1,1,0,0, 0,0, 0,0,  0,0,0, 'b11101));
        tv.push_back(mk(1,1,1,0, 0,0, 0,0,  0,0,0, 'b11101));
        tv.push_back(mk(1,0,0,0, 0,0, 1,6,  0,0,0, 'b11101));
        tv.push_back(mk(1,1,1,0, 0,0, 1,7,  1,0,2, 'b11101));
        tv.push_back(mk(1,0,1,0, 0,0, 0,0,  0,0,0, 'b11101));
        for (int k = 0; k < 7; k++) tv.push_back(mk(0,0,0,0, 1,0, 0,0, 0,0,0, 'b11101));
        tv.push_back(mk(0,0,0,0, 1,0, 0,0,  0,0,0, 'b11100));
        tv.push_back(mk(1,0,0,0, 0,0, 1,0,  0,0,0, 'b11100));
        tv.push_back(mk(1,1,0,0, 0,0, 1,1,  0,0,0, 'b11100));
        tv.push_back(mk(1,1,1,0, 0,0, 1,2,  1,0,3, 'b11101));

        drive(0, '0, 0, 0, 0);
        repeat (2) @(posedge memclk);
        #1;
        chk_zero("reset");
        memreset = 1'b1;

        foreach (tv[i]) begin
            d = mkd(tv[i].typ, tv[i].last);
            drive(tv[i].v, d, tv[i].q, tv[i].fv, tv[i].fq);
            @(posedge memclk);
            #1;
            cmp_out(tv[i].we, tv[i].addr, d, tv[i].cv, tv[i].cq, tv[i].cw, tv[i].ne);
        end
`ifdef SRAM_OQ_DROP_CNT_EN
        chk("drop_count0", bus.drop_count[15:0], 2);
        chk("drop_count2", bus.drop_count[47:32], 0);
        chk("drop_count3", bus.drop_count[63:48], 1);
`endif

        // Reset lands during the third word of a packet
        drive(1, mkd(0, 0), 2, 0, 0);
        @(posedge memclk); #1;
        drive(1, mkd(1, 0), 2, 0, 0);
        @(posedge memclk); #1;
        drive(1, mkd(1, 0), 2, 0, 0);
        #2;
        memreset = 1'b0;
        #1;
        chk_zero("async_reset");
        drive(0, '0, 0, 0, 0);
        @(posedge memclk); #1;
        memreset = 1'b1;
        d = mkd(0, 1);
        drive(1, d, 2, 0, 0);
        @(posedge memclk); #1;
        cmp_out(1, 6'd16, d, 1, 2, 1, 5'b00100);

        drive(0, '0, 0, 0, 0);
        memreset = 1'b0;
        @(posedge memclk); #1;
        memreset = 1'b1;
        m_reset();
        rq = 0;
        for (int i = 0; i < 4000; i++) begin
            rv = ($urandom % 4) != 0;
            rtyp = ($urandom % 4 == 0) ? 0 : int'($urandom_range(1, 7));
            rlast = ($urandom % 3 == 0) ? 1 : 0;
            if (rv && rtyp == 0)
                rq = ($urandom % 12 == 0) ? int'($urandom_range(5, 7)) : int'($urandom_range(0, 4));
            rfv = ($urandom % 4) < (i < 2000 ? 1 : 3);
            rfq = int'($urandom_range(0, 5));
            d = mkd(rtyp, rlast);
            drive(rv, d, rq, rfv, rfq);
            m_cycle(rv, d, rq, rfv, rfq);
            @(posedge memclk);
            #1;
            cmp_out(e_we, e_addr, e_data, e_cv, e_cq, e_cw, m_ne());
        end
`ifdef SRAM_OQ_DROP_CNT_EN
        for (int i = 0; i < NQ; i++) chk("drop_count_rand", bus.drop_count[i*16 +: 16], m_drop[i]);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
